// File: rtl/uart_pkg.sv
// UART shared constants.
// Byte width and receive-buffer defaults.
package uart_pkg;
  localparam int UART_BYTE_W   = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AFULL = 12;
endpackage

// File: rtl/uart_fifo_mem.sv
// Receive FIFO storage array.
// One write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_BYTE_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_BYTE_W-1:0] rdata
);

  logic [UART_BYTE_W-1:0] mem [DEPTH];

  // Write the accepted byte; storage is never reset
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer between the byte receiver
// and the bus bridge; show-ahead head byte.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = RX_FIFO_DEPTH,
  parameter int AFULL_LEVEL = RX_FIFO_AFULL
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [UART_BYTE_W-1:0]   in_data,
  input  logic                     in_valid,
  output logic [UART_BYTE_W-1:0]   rx_data,
  output logic                     rx_valid,
  input  logic                     rx_read,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     ovf_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [UART_BYTE_W-1:0] head;
  logic                   full;
  logic                   do_pop;
  logic                   do_push;
  logic                   drop;
  logic [LW-1:0]          level_nxt;

  // A pop frees the slot the same-cycle push
  // needs, so a full FIFO still accepts it.
  always_comb begin
    full      = (level == LW'(DEPTH));
    do_pop    = rx_read && rx_valid;
    do_push   = in_valid && (!full || do_pop);
    drop      = in_valid && full && !do_pop;
    level_nxt = level + LW'(do_push) - LW'(do_pop);
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers, level and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      rx_valid    <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      level       <= level_nxt;
      rx_valid    <= (level_nxt != '0);
      almost_full <= (level_nxt >= LW'(AFULL_LEVEL));
      if (drop)
        overflow <= 1'b1;
      else if (ovf_clear)
        overflow <= 1'b0;
    end
  end

  assign rx_data = rx_valid ? head : '0;

endmodule
